qeciphy_tx_frame_sequencer: RTL

- Upstream timing and mode controller for qeciphy_tx_packet_gen.
- Generates the per-cycle frame-slot boundaries `faw_boundary_o` and `crc_boundary_o`.
- Generates the one-hot transmit mode `tx_off_o`/`tx_idle_o`/`tx_active_o`.
- Mode changes are gated so they occur only on FAW boundaries, so the packet generator always sees a legal, frame-aligned boundary and mode stream.

---
 rtl/qeciphy_pkg.sv | 14 +
 rtl/qeciphy_tx_slot_counter.sv | 86 ++++++++
 rtl/qeciphy_tx_frame_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/qeciphy_pkg.sv
// Shared types and default geometry for the qeciphy transmit path.
// Mode encoding is one-hot so the mode register drives the mode outputs directly.
package qeciphy_pkg;

  localparam int unsigned QECIPHY_FAW_PERIOD = 64;
  localparam int unsigned QECIPHY_CRC_GROUP  = 7;

  typedef enum logic [2:0] {
    TX_OFF    = 3'b001,
    TX_IDLE   = 3'b010,
    TX_ACTIVE = 3'b100
  } tx_mode_t;

endpackage

// File: rtl/qeciphy_tx_slot_counter.sv
// Slot/group counters with start/stop control and registered FAW/CRC boundary decode.
// Also exports next-cycle run/FAW flags so the mode FSM can update in lockstep.
module qeciphy_tx_slot_counter
  import qeciphy_pkg::*;
#(
  parameter int unsigned FAW_PERIOD = QECIPHY_FAW_PERIOD,
  parameter int unsigned CRC_GROUP  = QECIPHY_CRC_GROUP
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          enable_i,
  output logic                          running_o,
  output logic [$clog2(FAW_PERIOD)-1:0] slot_o,
  output logic                          faw_boundary_o,
  output logic                          crc_boundary_o,
  output logic                          run_next_o,
  output logic                          faw_next_o
);

  localparam int unsigned SLOT_W  = $clog2(FAW_PERIOD);
  localparam int unsigned GROUP_W = (CRC_GROUP > 1) ? $clog2(CRC_GROUP) : 1;
  localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(FAW_PERIOD - 1);
  localparam logic [GROUP_W-1:0] LAST_GROUP = GROUP_W'(CRC_GROUP - 1);

  if (((FAW_PERIOD - 1) % CRC_GROUP) != 0) begin : g_bad_geometry
    $error("FAW_PERIOD-1 must be a multiple of CRC_GROUP");
  end

  logic               running_q, running_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [GROUP_W-1:0] group_q, group_d;
  logic               faw_q, faw_d;
  logic               crc_q, crc_d;

  always_comb begin
    running_d = running_q;
    slot_d    = slot_q;
    group_d   = group_q;
    if (!running_q) begin
      if (enable_i) begin
        running_d = 1'b1;
        slot_d    = '0;
        group_d   = '0;
      end
    end else if (slot_q == LAST_SLOT) begin
      // Stop requests take effect only here, so a frame is never cut short.
      running_d = enable_i;
      slot_d    = '0;
      group_d   = '0;
    end else begin
      slot_d = slot_q + 1'b1;
      // Slot 0 is the FAW, so grouping starts counting from slot 1.
      if (slot_q == '0 || group_q == LAST_GROUP) begin
        group_d = '0;
      end else begin
        group_d = group_q + 1'b1;
      end
    end
    faw_d = running_d && (slot_d == '0);
    crc_d = running_d && (slot_d != '0) && (group_d == LAST_GROUP);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      running_q <= 1'b0;
      slot_q    <= '0;
      group_q   <= '0;
      faw_q     <= 1'b0;
      crc_q     <= 1'b0;
    end else begin
      running_q <= running_d;
      slot_q    <= slot_d;
      group_q   <= group_d;
      faw_q     <= faw_d;
      crc_q     <= crc_d;
    end
  end

  assign running_o      = running_q;
  assign slot_o         = slot_q;
  assign faw_boundary_o = faw_q;
  assign crc_boundary_o = crc_q;
  assign run_next_o     = running_d;
  assign faw_next_o     = faw_d;

endmodule

// File: rtl/qeciphy_tx_frame_sequencer.sv
// Frame timing and frame-aligned transmit mode control for qeciphy_tx_packet_gen.
// Optional status outputs (frame_cnt_o, mode_chg_o) with QECIPHY_TX_FRAME_SEQ_STATUS_EN.
module qeciphy_tx_frame_sequencer
  import qeciphy_pkg::*;
#(
  parameter int unsigned FAW_PERIOD = QECIPHY_FAW_PERIOD,
  parameter int unsigned CRC_GROUP  = QECIPHY_CRC_GROUP
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          enable_i,
  input  logic                          tx_en_i,
  input  logic                          data_en_i,
  output logic                          faw_boundary_o,
  output logic                          crc_boundary_o,
  output logic                          tx_off_o,
  output logic                          tx_idle_o,
  output logic                          tx_active_o,
  output logic                          running_o,
  output logic [$clog2(FAW_PERIOD)-1:0] slot_o
`ifdef QECIPHY_TX_FRAME_SEQ_STATUS_EN
  ,
  output logic [15:0]                   frame_cnt_o,
  output logic [0:0]                    mode_chg_o
`endif
);

  logic run_next;
  logic faw_next;

  qeciphy_tx_slot_counter #(
    .FAW_PERIOD (FAW_PERIOD),
    .CRC_GROUP  (CRC_GROUP)
  ) u_slot_counter (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .enable_i       (enable_i),
    .running_o      (running_o),
    .slot_o         (slot_o),
    .faw_boundary_o (faw_boundary_o),
    .crc_boundary_o (crc_boundary_o),
    .run_next_o     (run_next),
    .faw_next_o     (faw_next)
  );

  tx_mode_t mode_q, mode_d, target;

  always_comb begin
    target = !tx_en_i ? TX_OFF : (data_en_i ? TX_ACTIVE : TX_IDLE);
    mode_d = mode_q;
    if (!run_next) begin
      mode_d = TX_OFF;
    end else if (faw_next) begin
      unique case (mode_q)
        // OFF must pass through one IDLE frame before going ACTIVE.
        TX_OFF:              mode_d = (target == TX_ACTIVE) ? TX_IDLE : target;
        TX_IDLE, TX_ACTIVE:  mode_d = target;
        default:             mode_d = TX_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q <= TX_OFF;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign {tx_active_o, tx_idle_o, tx_off_o} = mode_q;

`ifdef QECIPHY_TX_FRAME_SEQ_STATUS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        mode_chg_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (!run_next) begin
      frame_cnt_d = '0;
    end else if (faw_next && running_o && (frame_cnt_q != 16'hFFFF)) begin
      // FAW next while already running is a completed-frame wrap.
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_cnt_q <= '0;
      mode_chg_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      mode_chg_q  <= faw_next && (mode_d != mode_q);
    end
  end

  assign frame_cnt_o   = frame_cnt_q;
  assign mode_chg_o[0] = mode_chg_q;
`endif

endmodule
